triangle_bbox_scan: RTL and testbench

TRIANGLE_BBOX_SCAN -- requirements
Module: triangle_bbox_scan

---
 rtl/triangle_bbox_scan.sv | 164 ++++++++++++++++
 tb/tb_triangle_bbox_scan.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_bbox_scan.sv
// Triangle bounding-box scanner. Latches a triangle, computes its screen-clipped
// bounding box, rasters every coordinate of the box out to an external fill test,
// and turns the test's delayed answers into a stream of covered pixels.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a triangle, tri_ready high
// BOUND | one cycle: bounding box computed, off-screen boxes rejected
// SCAN  | one box coordinate presented per cycle in raster order
// DRAIN | waiting for the last coordinate to clear the fill latency
module triangle_bbox_scan #(
    parameter int H_MAX        = 1279,
    parameter int V_MAX        = 719,
    parameter int FILL_LATENCY = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tri_valid,
    output logic                    tri_ready,
    input  logic [2:0][1:0][10:0]   triangle,
    output logic [2:0][1:0][10:0]   tri_held,
    output logic [10:0]             hcount,
    output logic [10:0]             vcount,
    input  logic                    is_within,
    output logic                    px_valid,
    output logic [10:0]             px_x,
    output logic [10:0]             px_y,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {S_IDLE, S_BOUND, S_SCAN, S_DRAIN} state_t;

    localparam logic [10:0] H_LIM = 11'(H_MAX);
    localparam logic [10:0] V_LIM = 11'(V_MAX);

    state_t state, state_nxt;

    logic [10:0] bx_min, bx_max, by_min, by_max;
    logic [10:0] bx_max_raw, by_max_raw;
    logic        off_screen;
    logic [10:0] xmin_r, xmax_r, ymax_r;
    logic        scan_valid, scan_last;

    logic [FILL_LATENCY-1:0]        dly_valid;
    logic [FILL_LATENCY-1:0]        dly_last;
    logic [FILL_LATENCY-1:0][10:0]  dly_h;
    logic [FILL_LATENCY-1:0][10:0]  dly_v;
    logic                           dly_last_out;

    function automatic logic [10:0] min3(input logic [10:0] a, input logic [10:0] b,
                                         input logic [10:0] c);
        logic [10:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [10:0] max3(input logic [10:0] a, input logic [10:0] b,
                                         input logic [10:0] c);
        logic [10:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Bounding box of the held triangle; maxima clipped to the visible area.
    always_comb begin
        bx_min     = min3(tri_held[0][0], tri_held[1][0], tri_held[2][0]);
        by_min     = min3(tri_held[0][1], tri_held[1][1], tri_held[2][1]);
        bx_max_raw = max3(tri_held[0][0], tri_held[1][0], tri_held[2][0]);
        by_max_raw = max3(tri_held[0][1], tri_held[1][1], tri_held[2][1]);
        bx_max     = (bx_max_raw > H_LIM) ? H_LIM : bx_max_raw;
        by_max     = (by_max_raw > V_LIM) ? V_LIM : by_max_raw;
        off_screen = (bx_min > H_LIM) || (by_min > V_LIM);
    end

    assign scan_valid   = (state == S_SCAN);
    assign scan_last    = scan_valid && (hcount == xmax_r) && (vcount == ymax_r);
    assign dly_last_out = dly_last[FILL_LATENCY-1];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (tri_valid)    state_nxt = S_BOUND;
            S_BOUND: state_nxt = off_screen ? S_IDLE : S_SCAN;
            S_SCAN:  if (scan_last)    state_nxt = S_DRAIN;
            S_DRAIN: if (dly_last_out) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs; done fires on rejection in BOUND or when the last tag emerges.
    always_comb begin
        tri_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        done      = ((state == S_BOUND) && off_screen) ||
                    ((state == S_DRAIN) && dly_last_out);
    end

    // Triangle latch, box registers and the raster counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            tri_held <= '0;
            hcount   <= '0;
            vcount   <= '0;
            xmin_r   <= '0;
            xmax_r   <= '0;
            ymax_r   <= '0;
        end else begin
            if (state == S_IDLE && tri_valid) begin
                tri_held <= triangle;
            end
            if (state == S_BOUND && !off_screen) begin
                hcount <= bx_min;
                vcount <= by_min;
                xmin_r <= bx_min;
                xmax_r <= bx_max;
                ymax_r <= by_max;
            end
            // The last coordinate is held rather than wrapped so the counters
            // stay put once scanning ends.
            if (scan_valid && !scan_last) begin
                if (hcount == xmax_r) begin
                    hcount <= xmin_r;
                    vcount <= vcount + 11'd1;
                end else begin
                    hcount <= hcount + 11'd1;
                end
            end
        end
    end

    // Delay line aligning scan coordinates with the fill test's answer.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_valid <= '0;
            dly_last  <= '0;
            dly_h     <= '0;
            dly_v     <= '0;
        end else begin
            dly_valid[0] <= scan_valid;
            dly_last[0]  <= scan_last;
            dly_h[0]     <= hcount;
            dly_v[0]     <= vcount;
            for (int i = 1; i < FILL_LATENCY; i++) begin
                dly_valid[i] <= dly_valid[i-1];
                dly_last[i]  <= dly_last[i-1];
                dly_h[i]     <= dly_h[i-1];
                dly_v[i]     <= dly_v[i-1];
            end
        end
    end

    assign px_valid = dly_valid[FILL_LATENCY-1] & is_within;
    assign px_x     = dly_h[FILL_LATENCY-1];
    assign px_y     = dly_v[FILL_LATENCY-1];

endmodule

// File: tb/tb_triangle_bbox_scan.sv
// Bench for triangle_bbox_scan: emulates a 3-cycle edge-function fill test and
// checks the pixel stream, done timing and handshake against a raster model.
module tb_triangle_bbox_scan;

    typedef logic [2:0][1:0][10:0] tri_t;

    localparam int HM = 1279;
    localparam int VM = 719;

    logic        clk = 1'b0;
    logic        rst;
    logic        tri_valid;
    logic        tri_ready;
    tri_t        triangle;
    tri_t        tri_held;
    logic [10:0] hcount, vcount;
    logic        is_within;
    logic        px_valid;
    logic [10:0] px_x, px_y;
    logic        busy, done;

    int vectors = 0;
    int errors  = 0;

    tri_t cur_tri = '0;
    logic [2:0] fp = '0;

    int exp_kq[$];
    int exp_xq[$];
    int exp_yq[$];
    int exp_done;
    int last_npix;

    triangle_bbox_scan #(.H_MAX(HM), .V_MAX(VM), .FILL_LATENCY(3)) dut (
        .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .triangle(triangle), .tri_held(tri_held), .hcount(hcount), .vcount(vcount),
        .is_within(is_within), .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Edge-inclusive point-in-triangle test, either winding.
    function automatic bit in_tri(input tri_t t, input int px, input int py);
        int x0, y0, x1, y1, x2, y2, e0, e1, e2;
        x0 = int'(t[0][0]); y0 = int'(t[0][1]);
        x1 = int'(t[1][0]); y1 = int'(t[1][1]);
        x2 = int'(t[2][0]); y2 = int'(t[2][1]);
        e0 = (x1 - x0) * (py - y0) - (y1 - y0) * (px - x0);
        e1 = (x2 - x1) * (py - y1) - (y2 - y1) * (px - x1);
        e2 = (x0 - x2) * (py - y2) - (y0 - y2) * (px - x2);
        return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
    endfunction

    // Downstream fill test emulation: answer appears three cycles after the coordinate.
    always @(posedge clk) begin
        fp[0] <= in_tri(cur_tri, int'(hcount), int'(vcount));
        fp[1] <= fp[0];
        fp[2] <= fp[1];
    end
    assign is_within = fp[2];

    function automatic tri_t mk_tri(input int ax, input int ay, input int bx, input int by,
                                    input int cx, input int cy);
        tri_t t;
        t[0][0] = 11'(ax); t[0][1] = 11'(ay);
        t[1][0] = 11'(bx); t[1][1] = 11'(by);
        t[2][0] = 11'(cx); t[2][1] = 11'(cy);
        return t;
    endfunction

    // Reference: raster the clipped box, record each covered pixel's cycle offset from accept.
    task automatic build_model(input tri_t t);
        int xs[3], ys[3];
        int xmin, xmax, ymin, ymax, idx;
        for (int i = 0; i < 3; i++) begin
            xs[i] = int'(t[i][0]);
            ys[i] = int'(t[i][1]);
        end
        xmin = xs[0]; xmax = xs[0]; ymin = ys[0]; ymax = ys[0];
        for (int i = 1; i < 3; i++) begin
            if (xs[i] < xmin) xmin = xs[i];
            if (xs[i] > xmax) xmax = xs[i];
            if (ys[i] < ymin) ymin = ys[i];
            if (ys[i] > ymax) ymax = ys[i];
        end
        if (xmax > HM) xmax = HM;
        if (ymax > VM) ymax = VM;
        exp_kq.delete(); exp_xq.delete(); exp_yq.delete();
        if (xmin > HM || ymin > VM) begin
            exp_done = 1;
        end else begin
            idx = 0;
            for (int y = ymin; y <= ymax; y++) begin
                for (int x = xmin; x <= xmax; x++) begin
                    if (in_tri(t, x, y)) begin
                        exp_kq.push_back(idx + 5);
                        exp_xq.push_back(x);
                        exp_yq.push_back(y);
                    end
                    idx++;
                end
            end
            exp_done = idx + 4;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    task automatic check_tri(input tri_t t, input bit nxt_v, input tri_t nxt_t);
        int ek, ex, ey;
        bit exp_dn, exp_rdy;
        build_model(t);
        last_npix = 0;
        cur_tri   = t;
        triangle  = t;
        tri_valid = 1'b1;
        vectors++;
        if (tri_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: got %b want 1", tri_ready);
        end
        @(posedge clk);
        #1;
        triangle  = nxt_t;
        tri_valid = nxt_v;
        for (int k = 1; k <= exp_done + 1; k++) begin
            @(negedge clk);
            exp_dn  = (k == exp_done);
            exp_rdy = (k > exp_done);
            if (k == 1) begin
                vectors++;
                if (tri_held !== t) begin
                    errors++;
                    $display("FAIL tri_held: got %h want %h", tri_held, t);
                end
            end
            vectors++;
            if (done !== exp_dn) begin
                errors++;
                $display("FAIL done k=%0d: got %b want %b", k, done, exp_dn);
            end
            vectors++;
            if (tri_ready !== exp_rdy || busy !== !exp_rdy) begin
                errors++;
                $display("FAIL ready_busy k=%0d: got %b/%b want %b/%b",
                         k, tri_ready, busy, exp_rdy, !exp_rdy);
            end
            if (px_valid === 1'b1) begin
                last_npix++;
                vectors++;
                if (exp_kq.size() == 0) begin
                    errors++;
                    $display("FAIL extra_pixel k=%0d: got (%0d,%0d) want none", k, px_x, px_y);
                end else begin
                    ek = exp_kq.pop_front();
                    ex = exp_xq.pop_front();
                    ey = exp_yq.pop_front();
                    if (k != ek || int'(px_x) != ex || int'(px_y) != ey) begin
                        errors++;
                        $display("FAIL pixel: got (%0d,%0d)@%0d want (%0d,%0d)@%0d",
                                 px_x, px_y, k, ex, ey, ek);
                    end
                end
                vectors++;
                if (int'(px_x) > HM) begin
                    errors++;
                    $display("FAIL clip_x: got %0d want <=%0d", px_x, HM);
                end
            end else if (px_valid !== 1'b0) begin
                vectors++;
                errors++;
                $display("FAIL px_valid_x k=%0d: got %b want 0/1", k, px_valid);
            end
        end
        vectors++;
        if (exp_kq.size() != 0) begin
            errors++;
            $display("FAIL missing_pixels: got %0d left want 0", exp_kq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tri_valid = 1'b0;
        triangle = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (tri_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || px_valid !== 1'b0 ||
            hcount !== 11'd0 || vcount !== 11'd0 || px_x !== 11'd0 || px_y !== 11'd0 ||
            tri_held !== '0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b busy=%b done=%b pv=%b h=%0d v=%0d px=%0d py=%0d held=%h want 1 0 0 0 0 0 0 0 0",
                     tri_ready, busy, done, px_valid, hcount, vcount, px_x, px_y, tri_held);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        check_tri(mk_tri(10, 10, 20, 10, 10, 20), 1'b0, '0);
        vectors++;
        if (last_npix != 66) begin
            errors++;
            $display("FAIL count_66: got %0d want 66", last_npix);
        end
        check_tri(mk_tri(5, 7, 5, 7, 5, 7), 1'b0, '0);
        vectors++;
        if (last_npix != 1) begin
            errors++;
            $display("FAIL single_px: got %0d want 1", last_npix);
        end
        check_tri(mk_tri(1300, 3, 1300, 9, 1300, 4), 1'b0, '0);
        check_tri(mk_tri(4, 800, 9, 900, 6, 760), 1'b0, '0);
        check_tri(mk_tri(1270, 0, 1500, 0, 1270, 5), 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        tri_t a, b;
        a = mk_tri(30, 40, 38, 44, 33, 49);
        b = mk_tri(31, 41, 36, 41, 31, 46);
        check_tri(a, 1'b1, b);
        check_tri(b, 1'b0, '0);
    endtask

    task automatic test_random();
        tri_t r;
        int bx, by;
        for (int n = 0; n < 25; n++) begin
            bx = $urandom_range(0, 1300);
            by = $urandom_range(0, 730);
            for (int i = 0; i < 3; i++) begin
                r[i][0] = 11'(bx + $urandom_range(0, 12));
                r[i][1] = 11'(by + $urandom_range(0, 12));
            end
            check_tri(r, 1'b0, '0);
        end
    endtask

    task automatic test_mid_reset();
        cur_tri   = mk_tri(100, 100, 140, 100, 100, 140);
        triangle  = cur_tri;
        tri_valid = 1'b1;
        @(posedge clk);
        #1;
        tri_valid = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL midrst_early_done k=%0d: got %b want 0", k, done);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (px_valid !== 1'b0 || busy !== 1'b0 || tri_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: got pv=%b busy=%b rdy=%b done=%b want 0 0 1 0",
                     px_valid, busy, tri_ready, done);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || px_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_quiet k=%0d: got done=%b pv=%b busy=%b want 0 0 0",
                         k, done, px_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_directed();
        test_back_to_back();
        test_random();
        test_mid_reset();
        check_tri(mk_tri(7, 9, 12, 9, 7, 13), 1'b0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
